// File: rtl/dcache_sram_arbiter.sv
// rtl/dcache_sram_arbiter.sv - D-cache SRAM port arbiter with snoop priority, lock ownership and lock watchdog
// Optional: define DCACHE_ARB_RR_EN for round-robin among ports 1..NR_PORTS-1 (default is fixed priority).
module dcache_sram_arbiter #(
   parameter int unsigned NR_PORTS = 4,
   parameter int unsigned INDEX_W  = 12,
   parameter int unsigned TAG_W    = 44,
   parameter int unsigned DATA_W   = 128,
   parameter int unsigned BE_W     = 16,
   parameter int unsigned MAX_LOCK = 64
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NR_PORTS-1:0]          req_i,
   input  logic [NR_PORTS-1:0]          lock_i,
   input  logic [NR_PORTS-1:0]          we_i,
   input  logic [NR_PORTS*INDEX_W-1:0]  addr_i,
   input  logic [NR_PORTS*TAG_W-1:0]    tag_i,
   input  logic [NR_PORTS*DATA_W-1:0]   wdata_i,
   input  logic [NR_PORTS*BE_W-1:0]     be_i,
   output logic [NR_PORTS-1:0]          gnt_o,
   output logic [NR_PORTS-1:0]          rvalid_o,
   output logic                         sram_req_o,
   output logic                         sram_we_o,
   output logic [INDEX_W-1:0]           sram_addr_o,
   output logic [TAG_W-1:0]             sram_tag_o,
   output logic [DATA_W-1:0]            sram_wdata_o,
   output logic [BE_W-1:0]              sram_be_o,
   input  logic                         sram_gnt_i,
   output logic                         updating_o,
   output logic                         lock_err_o
);

   localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rd_id_q, rd_id_d;
   logic               rd_pend_q, rd_pend_d;
   logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic               lock_err_q, lock_err_d;
   logic [IDX_W-1:0]   win;
   logic               win_vld;
   logic [IDX_W-1:0]   sel;
   logic               fwd;
   logic               wd_trip;

`ifdef DCACHE_ARB_RR_EN
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

   // Port 0 (snoop) always wins; the rest search upward from rr_ptr_q or by fixed index.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      if (req_i[0]) begin
         win_vld = 1'b1;
      end else begin
`ifdef DCACHE_ARB_RR_EN
         for (int p = 1; p < NR_PORTS; p++) begin
            if (!win_vld && req_i[p] && (IDX_W'(p) >= rr_ptr_q)) begin
               win_vld = 1'b1;
               win     = IDX_W'(p);
            end
         end
         for (int p = 1; p < NR_PORTS; p++) begin
            if (!win_vld && req_i[p] && (IDX_W'(p) < rr_ptr_q)) begin
               win_vld = 1'b1;
               win     = IDX_W'(p);
            end
         end
`else
         for (int p = 1; p < NR_PORTS; p++) begin
            if (!win_vld && req_i[p]) begin
               win_vld = 1'b1;
               win     = IDX_W'(p);
            end
         end
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rd_pend_d  = 1'b0;
      rd_id_d    = rd_id_q;
      lock_cnt_d = lock_cnt_q;
      lock_err_d = lock_err_q;
      sel        = win;
      fwd        = 1'b0;
      wd_trip    = 1'b0;
      gnt_o      = '0;
      unique case (state_q)
         IDLE: begin
            fwd = win_vld;
            if (win_vld && sram_gnt_i) begin
               gnt_o[win] = 1'b1;
               rd_pend_d  = ~we_i[win];
               rd_id_d    = win;
               if (lock_i[win]) begin
                  state_d    = LOCKED;
                  owner_d    = win;
                  lock_cnt_d = '0;
               end
            end
         end
         LOCKED: begin
            sel        = owner_q;
            wd_trip    = (lock_cnt_q >= CNT_W'(MAX_LOCK - 1));
            lock_cnt_d = (lock_cnt_q == CNT_W'(MAX_LOCK)) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
            // Release cycle never grants; new requesters compete in the next IDLE cycle.
            if (!req_i[owner_q] || !lock_i[owner_q] || wd_trip) begin
               state_d = IDLE;
               if (wd_trip) lock_err_d = 1'b1;
            end else begin
               fwd = 1'b1;
               if (sram_gnt_i) begin
                  gnt_o[owner_q] = 1'b1;
                  rd_pend_d      = ~we_i[owner_q];
                  rd_id_d        = owner_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (!rst_ni) begin
         gnt_o = '0;
         fwd   = 1'b0;
      end
   end

`ifdef DCACHE_ARB_RR_EN
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if ((state_q == IDLE) && win_vld && sram_gnt_i && (win != '0))
         rr_ptr_d = (win == IDX_W'(NR_PORTS - 1)) ? IDX_W'(1) : win + IDX_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_ptr_q <= IDX_W'(1);
      else         rr_ptr_q <= rr_ptr_d;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rd_id_q    <= '0;
         rd_pend_q  <= 1'b0;
         lock_cnt_q <= '0;
         lock_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rd_id_q    <= rd_id_d;
         rd_pend_q  <= rd_pend_d;
         lock_cnt_q <= lock_cnt_d;
         lock_err_q <= lock_err_d;
      end
   end

   always_comb begin
      rvalid_o = '0;
      if (rd_pend_q) rvalid_o[rd_id_q] = 1'b1;
   end

   assign sram_req_o   = fwd;
   assign sram_we_o    = fwd & we_i[sel];
   assign sram_addr_o  = addr_i[32'(sel)*INDEX_W +: INDEX_W];
   assign sram_tag_o   = tag_i[32'(sel)*TAG_W +: TAG_W];
   assign sram_wdata_o = wdata_i[32'(sel)*DATA_W +: DATA_W];
   assign sram_be_o    = be_i[32'(sel)*BE_W +: BE_W];
   assign updating_o   = (state_q == LOCKED) && (owner_q != '0);
   assign lock_err_o   = lock_err_q;

endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// tb/tb_dcache_sram_arbiter.sv - self-checking bench for dcache_sram_arbiter against a behavioural model
module tb_dcache_sram_arbiter;
   localparam int NP = 4, IW = 12, TW = 44, DW = 128, BW = 16, ML = 64;
`ifdef DCACHE_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [NP-1:0]     req_i, lock_i, we_i;
   logic [NP*IW-1:0]  addr_i;
   logic [NP*TW-1:0]  tag_i;
   logic [NP*DW-1:0]  wdata_i;
   logic [NP*BW-1:0]  be_i;
   logic [NP-1:0]     gnt_o, rvalid_o;
   logic              sram_req_o, sram_we_o, sram_gnt_i;
   logic [IW-1:0]     sram_addr_o;
   logic [TW-1:0]     sram_tag_o;
   logic [DW-1:0]     sram_wdata_o;
   logic [BW-1:0]     sram_be_o;
   logic              updating_o, lock_err_o;

   dcache_sram_arbiter #(
      .NR_PORTS(NP), .INDEX_W(IW), .TAG_W(TW), .DATA_W(DW), .BE_W(BW), .MAX_LOCK(ML)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_i(req_i), .lock_i(lock_i), .we_i(we_i),
      .addr_i(addr_i), .tag_i(tag_i), .wdata_i(wdata_i), .be_i(be_i),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o),
      .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
      .sram_tag_o(sram_tag_o), .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o),
      .sram_gnt_i(sram_gnt_i), .updating_o(updating_o), .lock_err_o(lock_err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;

   // Reference model: lock owner, pointer, pending read and watchdog as plain integers.
   bit m_locked, m_pend, m_err;
   int m_owner, m_ptr, m_pend_id, m_cnt;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_pend = 0; m_err = 0;
      m_owner = 0; m_ptr = 1; m_pend_id = 0; m_cnt = 0;
   endtask

   task automatic step(input logic [NP-1:0] r, input logic [NP-1:0] l, input logic [NP-1:0] w, input logic g);
      logic [NP-1:0] e_gnt, e_rv;
      logic e_req;
      int win;
      bit wd;
      @(negedge clk_i);
      rst_ni = 1'b1; req_i = r; lock_i = l; we_i = w; sram_gnt_i = g;
      for (int p = 0; p < NP; p++) begin
         addr_i[p*IW +: IW]  = IW'($urandom);
         tag_i[p*TW +: TW]   = TW'({$urandom, $urandom});
         wdata_i[p*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
         be_i[p*BW +: BW]    = BW'($urandom);
      end
      #1;
      e_rv = '0;
      if (m_pend) e_rv[m_pend_id] = 1'b1;
      chk("rvalid", rvalid_o, e_rv);
      chk("updating", updating_o, m_locked && (m_owner != 0));
      chk("lock_err", lock_err_o, m_err);
      e_gnt = '0; win = -1; wd = 0; e_req = 0;
      if (!m_locked) begin
         if (r[0]) win = 0;
         else for (int k = 0; k < NP - 1; k++) begin
            int p;
            p = RR ? ((m_ptr - 1 + k) % (NP - 1)) + 1 : k + 1;
            if (win < 0 && r[p]) win = p;
         end
         e_req = (r != '0);
      end else begin
         wd = (m_cnt + 1 >= ML);
         if (r[m_owner] && l[m_owner] && !wd) begin
            win = m_owner;
            e_req = 1;
         end
      end
      if (win >= 0 && g) e_gnt[win] = 1'b1;
      chk("sram_req", sram_req_o, e_req);
      chk("gnt", gnt_o, e_gnt);
      if (win >= 0) begin
         chk("addr", sram_addr_o, addr_i[win*IW +: IW]);
         chk("tag", sram_tag_o, tag_i[win*TW +: TW]);
         chk("wdata", sram_wdata_o, wdata_i[win*DW +: DW]);
         chk("be", sram_be_o, be_i[win*BW +: BW]);
         chk("we", sram_we_o, w[win]);
      end
      m_pend = 0;
      if (m_locked) begin
         if (wd) m_err = 1;
         if (win < 0) m_locked = 0;
         if (m_cnt < ML) m_cnt++;
      end
      if (e_gnt != '0) begin
         m_pend = !w[win];
         m_pend_id = win;
         if (!m_locked) begin
            if (win > 0) m_ptr = (win == NP - 1) ? 1 : win + 1;
            if (l[win]) begin
               m_locked = 1; m_owner = win; m_cnt = 0;
            end
         end
      end
   endtask

   initial begin
      logic [NP-1:0] exp33 [3];
      rst_ni = 1'b0; req_i = '1; lock_i = '1; we_i = '0; sram_gnt_i = 1'b1;
      addr_i = '0; tag_i = '0; wdata_i = '0; be_i = '0;
      model_reset();
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_gnt", gnt_o, '0);
      chk("rst_rvalid", rvalid_o, '0);
      chk("rst_sram_req", sram_req_o, 1'b0);
      chk("rst_updating", updating_o, 1'b0);
      chk("rst_lock_err", lock_err_o, 1'b0);

      // Mixed ports 1 and 3
      step(4'b1010, 4'b0000, 4'b0000, 1'b1);
      chk("r29_first", gnt_o, 4'b0010);
      step(4'b1010, 4'b0000, 4'b0000, 1'b1);
      chk("r29_second", gnt_o, RR ? 4'b1000 : 4'b0010);

      // Snoop port wins; read returns next cycle
      step(4'b0111, 4'b0000, 4'b0000, 1'b1);
      chk("r30_gnt", gnt_o, 4'b0001);
      step(4'b0000, 4'b0000, 4'b0000, 1'b1);
      chk("r30_rvalid", rvalid_o, 4'b0001);

      exp33[0] = 4'b0010;
      exp33[1] = RR ? 4'b0100 : 4'b0010;
      exp33[2] = RR ? 4'b1000 : 4'b0010;
      for (int i = 0; i < 3; i++) begin
         step(4'b1110, 4'b0000, 4'b1110, 1'b1);
         chk("r33_gnt", gnt_o, exp33[i]);
      end

      // Port 2 locks while snoop waits
      step(4'b0100, 4'b0100, 4'b0000, 1'b1);
      chk("r31_acquire", gnt_o, 4'b0100);
      for (int i = 0; i < 5; i++) begin
         step(4'b0101, 4'b0100, 4'b0000, 1'b1);
         chk("r31_hold_gnt", gnt_o, 4'b0100);
         chk("r31_hold_upd", updating_o, 1'b1);
      end
      step(4'b0001, 4'b0000, 4'b0000, 1'b1);
      chk("r31_release_gnt", gnt_o, 4'b0000);
      step(4'b0001, 4'b0000, 4'b0000, 1'b1);
      chk("r31_snoop_gnt", gnt_o, 4'b0001);

      // Watchdog on a lock held too long
      step(4'b0010, 4'b0010, 4'b1111, 1'b1);
      for (int i = 0; i < ML; i++) step(4'b0010, 4'b0010, 4'b1111, 1'b1);
      chk("r32_trip_gnt", gnt_o, 4'b0000);
      step(4'b0000, 4'b0000, 4'b0000, 1'b1);
      chk("r32_err", lock_err_o, 1'b1);
      chk("r32_idle", updating_o, 1'b0);
      for (int i = 0; i < 3; i++) step(NP'($urandom), 4'b0000, NP'($urandom), 1'b1);
      chk("r32_sticky", lock_err_o, 1'b1);

      // Reset while locked with a read in flight
      step(4'b0100, 4'b0100, 4'b0000, 1'b1);
      step(4'b0100, 4'b0100, 4'b0000, 1'b1);
      chk("r34_pre_gnt", gnt_o, 4'b0100);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk("r34_gnt", gnt_o, '0);
      chk("r34_rvalid", rvalid_o, '0);
      chk("r34_sram_req", sram_req_o, 1'b0);
      chk("r34_updating", updating_o, 1'b0);
      chk("r34_lock_err", lock_err_o, 1'b0);
      model_reset();
      @(negedge clk_i);
      #1;
      chk("r34_rvalid_later", rvalid_o, '0);

      for (int i = 0; i < 1500; i++) begin
         logic [NP-1:0] r;
         r = NP'($urandom);
         step(r, r & NP'($urandom) & NP'($urandom), NP'($urandom), $urandom_range(0, 7) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
